// File: rtl/core_sequencer.sv
// core_sequencer
//   Multi-cycle fetch/execute sequencer for the single-issue core. It holds the
//   program counter and instruction register, and fetches over a request/valid
//   handshake. It turns the control path's enables into single, exclusive
//   strobes. It also provides run/halt and a sticky illegal-opcode trap.
//
// Ports
//   clk, rst_n        clock; synchronous active-low reset
//   run               1 = execute, 0 = stop at the next instruction boundary
//   imem_req/addr     fetch request (held until imem_rvalid) and address (= pc)
//   imem_rvalid/rdata fetch response, captured while imem_req=1
//   opcode, instr     instruction register fields for the control path
//   dec_reg_wr_en     control-path register write enable (sampled in EXEC)
//   dec_dmem_en       control-path store enable (sampled in EXEC)
//   dec_illegal       control-path undefined-opcode flag (sampled in EXEC)
//   reg_wr_strb       one-cycle register-file write strobe
//   dmem_wr/ready     store request held until accepted
//   pc                current program counter
//   busy              sequencer is fetching, executing or storing
//   trap              sticky illegal-opcode flag (cleared only by reset)
//   retired           retired-instruction count, wraps modulo 2^16
module core_sequencer #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 8,
    parameter int OP_W    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [OP_W-1:0]    opcode,
    output logic [INSTR_W-1:0] instr,
    input  logic               dec_reg_wr_en,
    input  logic               dec_dmem_en,
    input  logic               dec_illegal,
    output logic               reg_wr_strb,
    output logic               dmem_wr,
    input  logic               dmem_ready,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               trap,
    output logic [15:0]        retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_STORE,
        S_TRAP
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [INSTR_W-1:0] ir;
    logic               retire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pc      <= '0;
            ir      <= '0;
            retired <= '0;
        end else begin
            state <= state_next;
            if (state == S_FETCH && imem_rvalid) begin
                ir <= imem_rdata;
            end
            // pc wraps naturally at its own width.
            if (retire) begin
                pc      <= pc + 1'b1;
                retired <= retired + 16'd1;
            end
        end
    end

    always_comb begin
        state_next  = state;
        imem_req    = 1'b0;
        reg_wr_strb = 1'b0;
        dmem_wr     = 1'b0;
        retire      = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                // run is ignored so an in-flight fetch always completes.
                imem_req = 1'b1;
                if (imem_rvalid) begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                // Illegal beats store beats register write.
                if (dec_illegal) begin
                    state_next = S_TRAP;
                end else if (dec_dmem_en) begin
                    state_next = S_STORE;
                end else begin
                    reg_wr_strb = dec_reg_wr_en;
                    retire      = 1'b1;
                end
            end
            S_STORE: begin
                dmem_wr = 1'b1;
                if (dmem_ready) begin
                    retire = 1'b1;
                end
            end
            S_TRAP: begin
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (retire) begin
            state_next = run ? S_FETCH : S_IDLE;
        end
    end

    assign imem_addr = pc;
    assign instr     = ir;
    assign opcode    = ir[INSTR_W-1 -: OP_W];
    assign busy      = (state == S_FETCH) || (state == S_EXEC) || (state == S_STORE);
    assign trap      = (state == S_TRAP);

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle fetch/execute sequencer for the single-issue core. It owns the program counter and instruction register, and fetches from instruction memory over a request/valid handshake. It presents the opcode to the combinational control path and gates that path's register-write and data-memory enables into single, well-timed strobes. It sits between instruction memory, the control path and the register file / data memory, and provides run/halt and sticky illegal-opcode trap control.

## Interface

- PC_W, default 8: program counter / instruction address width.
- INSTR_W, default 8: instruction word width.
- OP_W, default 3: opcode field width, taken from the MSBs of the instruction word.
- clk  in  1  core clock; all state changes on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- run  in  1  level; 1 = execute, 0 = stop at the next instruction boundary.
- imem_req  out  1  instruction fetch request, held until accepted.
- imem_addr  out  PC_W  fetch address (= pc).
- imem_rvalid  in  1  fetch data valid; sampled only while imem_req=1.
- imem_rdata  in  INSTR_W  fetched instruction.
- opcode  out  OP_W  ir[INSTR_W-1 -: OP_W], fed to the control path.
- instr  out  INSTR_W  full instruction register, for operand fields.
- dec_reg_wr_en  in  1  control-path register write enable.
- dec_dmem_en  in  1  control-path data-memory store enable.
- dec_illegal  in  1  control path hit its default (undefined opcode) arm.
- reg_wr_strb  out  1  one-cycle register-file write strobe.
- dmem_wr  out  1  store request, held until dmem_ready.
- dmem_ready  in  1  data memory accepts the store this cycle.
- pc  out  PC_W  current program counter.
- busy  out  1  state is not IDLE or TRAP.
- trap  out  1  sticky illegal-opcode flag.
- retired  out  16  retired-instruction count; wraps modulo 2^16.

## Operation

- States: IDLE, FETCH, EXEC, STORE, TRAP.
- Reset: state=IDLE, pc=0, ir=0, retired=0. All outputs are 0; opcode and instr read 0.
- IDLE: no requests issued. If run=1, go to FETCH next cycle; pc is unchanged.
- FETCH: imem_req=1, imem_addr=pc.
  - On a cycle with imem_rvalid=1: ir<=imem_rdata, go to EXEC.
  - Otherwise stay in FETCH. run is ignored here; an in-flight fetch always completes.
- EXEC: opcode/instr reflect ir. dec_* are sampled this cycle only. Priority:
  - dec_illegal=1: go to TRAP. No strobe is issued, and pc and retired are unchanged.
  - dec_dmem_en=1: go to STORE. reg_wr_strb=0, even if dec_reg_wr_en=1.
  - Otherwise: reg_wr_strb=dec_reg_wr_en (combinational, this cycle only), and the instruction retires.
- STORE: dmem_wr=1 with ir held stable. When dmem_ready=1, the instruction retires. Otherwise stay in STORE.
- Retire, in the same cycle: pc<=pc+1, wrapping mod 2^PC_W (all-ones goes to 0); retired<=retired+1. Next state is FETCH if run=1, else IDLE.
- TRAP: trap=1 and busy=0. All strobes and requests are 0, and pc holds the address of the offending instruction. TRAP exits only on reset.
- Strobes are exclusive: at most one of imem_req, reg_wr_strb and dmem_wr is 1 in any cycle.

## Timing

- Zero-wait fetch (imem_rvalid=1 in the first FETCH cycle): an ALU or init instruction takes 2 cycles (FETCH, EXEC).
- A store takes at least 3 cycles (FETCH, EXEC, STORE), plus one cycle per dmem_ready=0 cycle.
- IDLE to the first imem_req: 1 cycle after run is sampled high.
- imem_rdata is captured at the rising edge where imem_req=1 and imem_rvalid=1.
- reg_wr_strb is asserted in the EXEC cycle; the register file writes at the end of that cycle.
- Reset mid-operation (rst_n=0 at any edge): next cycle is IDLE with reset values. A pending fetch or store is abandoned and imem_req/dmem_wr drop after that edge.
- run falling during a STORE stall: the store completes, then the core goes to IDLE.

## Test plan

- Reset, then run=1, zero-wait memory, dec_reg_wr_en=1 on 3 instructions: reg_wr_strb pulses at cycles 3, 5 and 7; pc=3 and retired=3 after the third retire.
- Fetch wait states: imem_rvalid held low 4 cycles: imem_req stays high with imem_addr constant for 5 cycles, and ir loads only on the rvalid edge.
- Store with dmem_ready low for 3 cycles: dmem_wr is high exactly 4 cycles, reg_wr_strb never asserts, and pc increments once.
- dec_illegal=1 at pc=5: trap=1 from the next cycle, pc stays 5, retired is unchanged. run toggling has no effect; rst_n=0 clears to IDLE with pc=0.
- PC wrap, PC_W=8: start 256 instructions, and after retire 256 pc=0. run dropped mid-fetch: the fetch and the instruction complete, then IDLE with busy=0.
- rst_n=0 during a STORE stall: the next cycle has dmem_wr=0, state IDLE, pc=0, retired=0.
